// File: rtl/mdio_config_sequencer.sv
// Boot-time PHY configuration over an MDIO master: table write, optional read-back
// verify, then single-transaction host pass-through.
module mdio_config_sequencer #(
  parameter logic [4:0]   PHY_ADDR    = 5'd0,
  parameter int           NUM_REGS    = 32,
  parameter logic [511:0] INIT_TABLE  = '0,
  parameter bit           VERIFY_EN   = 1'b1,
  parameter int           TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic        m_req,
  output logic        m_rw,
  output logic [4:0]  m_phy_addr,
  output logic [4:0]  m_reg_addr,
  output logic [15:0] m_wdata,
  input  logic        m_wr_done,
  input  logic        m_rd_done,
  input  logic [15:0] m_rdata,
  input  logic        h_req,
  input  logic        h_rw,
  input  logic [4:0]  h_reg_addr,
  input  logic [15:0] h_wdata,
  output logic        h_ack,
  output logic [15:0] h_rdata,
  output logic        init_done,
  output logic        init_err,
  output logic [5:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    W_ISSUE, W_WAIT, V_ISSUE, V_WAIT, DONE, READY, H_WAIT
  } state_t;

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0]     LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t        state, state_n;
  logic [4:0]    idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic          m_req_n, m_rw_n, h_ack_n, init_done_n, init_err_n;
  logic [4:0]    m_reg_addr_n;
  logic [15:0]   m_wdata_n, h_rdata_n;
  logic [5:0]    err_count_n;
  logic          err_ev;
  logic          last, timed_out, host_done;
  logic [15:0]   table_word;

  assign table_word = INIT_TABLE[{idx, 4'b0000} +: 16];
  assign last       = (idx == LAST_IDX);
  assign timed_out  = (timer == TO_LAST);
  assign host_done  = m_rw ? m_rd_done : m_wr_done;

  assign m_phy_addr = PHY_ADDR;
  // Combinational so that busy reads 0 while reset is held yet 1 on the very first cycle after.
  assign busy       = ~reset && (state != READY);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    timer_n      = timer;
    m_req_n      = m_req;
    m_rw_n       = m_rw;
    m_reg_addr_n = m_reg_addr;
    m_wdata_n    = m_wdata;
    h_ack_n      = 1'b0;
    h_rdata_n    = h_rdata;
    init_done_n  = init_done;
    err_ev       = 1'b0;

    case (state)
      W_ISSUE: begin
        m_rw_n       = 1'b0;
        m_reg_addr_n = idx;
        m_wdata_n    = table_word;
        m_req_n      = 1'b1;
        timer_n      = '0;
        state_n      = W_WAIT;
      end
      W_WAIT: begin
        if (m_wr_done || timed_out) begin
          m_req_n = 1'b0;
          err_ev  = ~m_wr_done;
          if (last) begin
            idx_n   = '0;
            state_n = VERIFY_EN ? V_ISSUE : DONE;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = W_ISSUE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      V_ISSUE: begin
        m_rw_n       = 1'b1;
        m_reg_addr_n = idx;
        m_req_n      = 1'b1;
        timer_n      = '0;
        state_n      = V_WAIT;
      end
      V_WAIT: begin
        if (m_rd_done || timed_out) begin
          m_req_n = 1'b0;
          err_ev  = m_rd_done ? (m_rdata != table_word) : 1'b1;
          if (last) begin
            idx_n   = '0;
            state_n = DONE;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = V_ISSUE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DONE: begin
        init_done_n = 1'b1;
        state_n     = READY;
      end
      READY: begin
        // The ack cycle itself is not a new request; h_req must still be high one cycle later.
        if (h_req && init_done && !h_ack) begin
          m_rw_n       = h_rw;
          m_reg_addr_n = h_reg_addr;
          m_wdata_n    = h_wdata;
          m_req_n      = 1'b1;
          timer_n      = '0;
          state_n      = H_WAIT;
        end
      end
      H_WAIT: begin
        if (host_done) begin
          m_req_n = 1'b0;
          h_ack_n = 1'b1;
          if (m_rw) h_rdata_n = m_rdata;
          state_n = READY;
        end else if (timed_out) begin
          m_req_n   = 1'b0;
          h_ack_n   = 1'b1;
          h_rdata_n = '1;
          state_n   = READY;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = W_ISSUE;
    endcase

    init_err_n  = init_err | err_ev;
    err_count_n = err_count;
    if (err_ev && (err_count != '1)) err_count_n = err_count + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= W_ISSUE;
      idx        <= '0;
      timer      <= '0;
      m_req      <= 1'b0;
      m_rw       <= 1'b0;
      m_reg_addr <= '0;
      m_wdata    <= '0;
      h_ack      <= 1'b0;
      h_rdata    <= '0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      timer      <= timer_n;
      m_req      <= m_req_n;
      m_rw       <= m_rw_n;
      m_reg_addr <= m_reg_addr_n;
      m_wdata    <= m_wdata_n;
      h_ack      <= h_ack_n;
      h_rdata    <= h_rdata_n;
      init_done  <= init_done_n;
      init_err   <= init_err_n;
      err_count  <= err_count_n;
    end
  end

endmodule

// File: tb/tb_mdio_config_sequencer.sv
// Directed bench for mdio_config_sequencer with a behavioural MDIO responder/register emulator.
module tb_mdio_config_sequencer;

  localparam logic [511:0] TBL = (512'h1140) | (512'h7949 << 16) | (512'h0141 << 32) |
                                 (512'hA5A5 << 48) | (512'h848b << 432) | (512'h0001 << 496);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_req, m_rw;
  logic [4:0]  m_phy_addr, m_reg_addr;
  logic [15:0] m_wdata;
  logic        m_wr_done, m_rd_done;
  logic [15:0] m_rdata;
  logic        h_req, h_rw;
  logic [4:0]  h_reg_addr;
  logic [15:0] h_wdata;
  logic        h_ack;
  logic [15:0] h_rdata;
  logic        init_done, init_err, busy;
  logic [5:0]  err_count;

  int tests = 0;
  int fails = 0;

  int          resp_delay = 40;
  int          drop_wr_reg = -1;
  int          bad_rd_reg = -1;
  int          rcnt;
  logic [15:0] mem [32];
  logic [4:0]  wlog_addr [$];
  logic [15:0] wlog_data [$];
  logic [4:0]  wlog_phy  [$];

  always #5 clk = ~clk;

  mdio_config_sequencer #(
    .PHY_ADDR   (5'd0),
    .NUM_REGS   (32),
    .INIT_TABLE (TBL),
    .VERIFY_EN  (1'b1),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_rw(m_rw), .m_phy_addr(m_phy_addr), .m_reg_addr(m_reg_addr),
    .m_wdata(m_wdata), .m_wr_done(m_wr_done), .m_rd_done(m_rd_done), .m_rdata(m_rdata),
    .h_req(h_req), .h_rw(h_rw), .h_reg_addr(h_reg_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .init_done(init_done), .init_err(init_err), .err_count(err_count), .busy(busy)
  );

  function automatic logic [15:0] exp_word(input int i);
    case (i)
      0:       return 16'h1140;
      1:       return 16'h7949;
      2:       return 16'h0141;
      3:       return 16'hA5A5;
      27:      return 16'h848b;
      31:      return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // MDIO responder: done pulse resp_delay cycles after m_req is first seen.
  initial begin
    m_wr_done = 1'b0;
    m_rd_done = 1'b0;
    m_rdata   = '0;
    rcnt      = 0;
    forever begin
      @(posedge clk); #1;
      m_wr_done = 1'b0;
      m_rd_done = 1'b0;
      if (reset || !m_req) rcnt = 0;
      else begin
        rcnt++;
        if (rcnt == resp_delay) begin
          if (m_rw) begin
            m_rdata   = (int'(m_reg_addr) == bad_rd_reg) ? 16'h0000 : mem[m_reg_addr];
            m_rd_done = 1'b1;
          end else if (int'(m_reg_addr) != drop_wr_reg) begin
            mem[m_reg_addr] = m_wdata;
            wlog_addr.push_back(m_reg_addr);
            wlog_data.push_back(m_wdata);
            wlog_phy.push_back(m_phy_addr);
            m_wr_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input int drop, input int bad);
    reset = 1'b1;
    h_req = 1'b0; h_rw = 1'b0; h_reg_addr = '0; h_wdata = '0;
    drop_wr_reg = drop;
    bad_rd_reg  = bad;
    repeat (3) tick();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    wlog_addr.delete(); wlog_data.delete(); wlog_phy.delete();
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (init_done) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic wait_wlog(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (wlog_addr.size() >= n) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic host_txn(input logic rw, input logic [4:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int acks, output bit ok);
    ok = 1'b0; acks = 0; rd = 'x;
    h_req = 1'b1; h_rw = rw; h_reg_addr = addr; h_wdata = wd;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (h_ack) begin ok = 1'b1; rd = h_rdata; acks = 1; h_req = 1'b0; break; end
    end
    h_req = 1'b0;
    tick();
    if (h_ack) acks++;
  endtask

  task automatic test_reset();
    apply_reset(-1, -1);
    tests++;
    if ({m_req, m_rw, m_phy_addr, m_reg_addr, m_wdata, h_ack, h_rdata,
         init_done, init_err, err_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: m_req=%b m_reg_addr=%0d m_wdata=%h init_done=%b init_err=%b err_count=%0d, required all 0",
               m_req, m_reg_addr, m_wdata, init_done, init_err, err_count);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b0;
    tick();
    tests++;
    if ({m_req, m_rw, m_reg_addr, m_wdata, busy} !== {1'b1, 1'b0, 5'd0, 16'h1140, 1'b1}) begin
      fails++;
      $display("FAIL first_write: m_req=%b m_rw=%b addr=%0d wdata=%h busy=%b, required 1 0 0 1140 1",
               m_req, m_rw, m_reg_addr, m_wdata, busy);
    end
  endtask

  task automatic test_write_phase();
    bit ok;
    wait_wlog(32, ok);
    tests++;
    if (!ok || wlog_addr.size() != 32) begin
      fails++; $display("FAIL write_count: got %0d writes required 32", wlog_addr.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        tests++;
        if (wlog_addr[i] !== 5'(i) || wlog_data[i] !== exp_word(i) || wlog_phy[i] !== 5'd0) begin
          fails++;
          $display("FAIL write_entry[%0d]: addr=%0d data=%h phy=%0d required addr=%0d data=%h phy=0",
                   i, wlog_addr[i], wlog_data[i], wlog_phy[i], i, exp_word(i));
        end
      end
    end
  endtask

  task automatic test_verify_pass();
    bit ok;
    wait_init(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL verify_pass_done: init_done=%b required 1", init_done); end
    tests++;
    if ({init_err, err_count, busy, m_req} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL verify_pass_status: init_err=%b err_count=%0d busy=%b m_req=%b required 0 0 0 0",
               init_err, err_count, busy, m_req);
    end
  endtask

  task automatic test_host();
    logic [15:0] rd; int acks; bit ok;
    host_txn(1'b1, 5'd2, 16'h0000, rd, acks, ok);
    tests++;
    if (!ok || rd !== 16'h0141 || acks != 1) begin
      fails++; $display("FAIL host_read2: rdata=%h acks=%0d required 0141 1", rd, acks);
    end
    host_txn(1'b0, 5'd0, 16'h9140, rd, acks, ok);
    tests++;
    if (!ok || acks != 1 || mem[0] !== 16'h9140) begin
      fails++; $display("FAIL host_write0: acks=%0d reg0=%h required 1 9140", acks, mem[0]);
    end
    host_txn(1'b1, 5'd0, 16'h0000, rd, acks, ok);
    tests++;
    if (!ok || rd !== 16'h9140 || acks != 1) begin
      fails++; $display("FAIL host_readback0: rdata=%h acks=%0d required 9140 1", rd, acks);
    end
    tests++;
    if (init_err !== 1'b0 || err_count !== 6'd0) begin
      fails++; $display("FAIL host_no_err: init_err=%b err_count=%0d required 0 0", init_err, err_count);
    end
  endtask

  task automatic test_verify_fail();
    bit ok;
    apply_reset(-1, 1);
    reset = 1'b0;
    wait_init(ok);
    tests++;
    if (!ok || {init_done, init_err, err_count} !== {1'b1, 1'b1, 6'd1}) begin
      fails++;
      $display("FAIL verify_fail: init_done=%b init_err=%b err_count=%0d required 1 1 1",
               init_done, init_err, err_count);
    end
  endtask

  task automatic test_timeout();
    bit ok; int n;
    apply_reset(5, -1);
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (m_req && !m_rw && m_reg_addr == 5'd5) begin ok = 1'b1; break; end
      tick();
    end
    n = 0;
    while (ok && m_req && n < 500) begin n++; tick(); end
    tests++;
    if (!ok || n != 64) begin fails++; $display("FAIL timeout_len: m_req high %0d cycles required 64", n); end
    wait_wlog(6, ok);
    tests++;
    if (!ok || wlog_addr[5] !== 5'd6) begin
      fails++; $display("FAIL timeout_next: next write addr=%0d required 6", ok ? wlog_addr[5] : 5'd0);
    end
    wait_init(ok);
    tests++;
    if (!ok || {init_err, err_count} !== {1'b1, 6'd1}) begin
      fails++; $display("FAIL timeout_err: init_err=%b err_count=%0d required 1 1", init_err, err_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; bit early;
    apply_reset(-1, -1);
    h_req = 1'b1; h_rw = 1'b1; h_reg_addr = 5'd27;
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (m_req && !m_rw && m_reg_addr == 5'd10) begin ok = 1'b1; break; end
      tick();
    end
    reset = 1'b1;
    tick();
    tests++;
    if (!ok || m_req !== 1'b0) begin fails++; $display("FAIL reset_mid_mreq: m_req=%b required 0", m_req); end
    tick();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    wlog_addr.delete(); wlog_data.delete(); wlog_phy.delete();
    reset = 1'b0;
    wait_wlog(1, ok);
    tests++;
    if (!ok || wlog_addr[0] !== 5'd0) begin
      fails++; $display("FAIL reset_mid_restart: first write addr=%0d required 0", ok ? wlog_addr[0] : 5'd31);
    end
    ok = 1'b0; early = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (m_req && m_rw && m_reg_addr == 5'd27 && !init_done) early = 1'b0;
      if (h_ack) begin ok = 1'b1; if (!init_done || wlog_addr.size() != 32) early = 1'b1; break; end
      tick();
    end
    h_req = 1'b0;
    tests++;
    if (!ok || early || h_rdata !== 16'h848b) begin
      fails++;
      $display("FAIL pending_host: ack=%b before_init=%b init_done=%b rdata=%h required ack after init, 848b",
               ok, early, init_done, h_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_phase();
    test_verify_pass();
    test_host();
    test_verify_fail();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
